// File: rtl/buffer_readout_if.sv
// Byte stream from the buffer reader to the Tx protocol: rdy/ack/eof handshake.
interface buffer_readout_if;
  logic [7:0] tx_data;
  logic       tx_rdy;
  logic       tx_eof;
  logic       tx_ack;

  modport master (
    output tx_data,
    output tx_rdy,
    output tx_eof,
    input  tx_ack
  );

  modport slave (
    input  tx_data,
    input  tx_rdy,
    input  tx_eof,
    output tx_ack
  );
endinterface

// File: rtl/buffer_readout.sv
// Reads the last num_samples captured samples from the circular acquisition RAM,
// oldest first, and streams them one byte at a time over the Tx handshake.
module buffer_readout #(
  parameter int unsigned REG_DATA_WIDTH = 16,
  parameter int unsigned BITS_ADC       = 8,
  parameter int unsigned RAM_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rqst_data,
  input  logic                      stop,
  input  logic [REG_DATA_WIDTH-1:0] num_samples,
  input  logic [RAM_ADDR_WIDTH-1:0] wr_ptr,
  output logic                      rd_en,
  output logic [RAM_ADDR_WIDTH-1:0] rd_addr,
  input  logic [BITS_ADC-1:0]       rd_data,
  buffer_readout_if.master          tx,
  output logic                      busy
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
  // One extra bit so a full-depth frame count is representable.
  localparam int unsigned CNT_W     = RAM_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_PRESENT
  } state_t;

  state_t                    state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RAM_ADDR_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]          rem_q, rem_d;
  logic [7:0]                data_q, data_d;
  logic                      eof_q, eof_d;
  logic [CNT_W-1:0]          n_eff;

  // Effective frame length: requested count clamped to the RAM depth.
  always_comb begin
    if (64'(num_samples) > 64'(RAM_DEPTH)) begin
      n_eff = CNT_W'(RAM_DEPTH);
    end else begin
      n_eff = CNT_W'(num_samples);
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      hold_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      eof_q   <= eof_d;
    end
  end

  // Next-state and datapath updates; stop overrides any transition out of a busy state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    rem_d   = rem_q;
    data_d  = data_q;
    eof_d   = eof_q;

    unique case (state_q)
      S_IDLE: begin
        if (rqst_data && !stop && (n_eff != '0)) begin
          addr_d  = wr_ptr - n_eff[RAM_ADDR_WIDTH-1:0];
          rem_d   = n_eff;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        hold_d  = addr_q;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        data_d  = 8'(rd_data);
        eof_d   = (rem_q == CNT_W'(1));
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (tx.tx_ack) begin
          if (eof_q) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // rd_addr shows the live address only while reading; otherwise it holds the last one read.
  assign rd_en      = (state_q == S_FETCH);
  assign rd_addr    = rd_en ? addr_q : hold_q;
  assign tx.tx_rdy  = (state_q == S_PRESENT);
  assign tx.tx_eof  = (state_q == S_PRESENT) && eof_q;
  assign tx.tx_data = data_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_buffer_readout.sv
// Directed-plus-random bench for buffer_readout with a behavioural RAM and frame model.
module tb_buffer_readout;

  logic        clk;
  logic        rst;
  logic        rqst_data;
  logic        stop;
  logic [15:0] num_samples;
  logic [7:0]  wr_ptr;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        busy;

  logic [7:0]  mem [256];

  int checks = 0;
  int errors = 0;

  buffer_readout_if bus ();

  buffer_readout #(
    .REG_DATA_WIDTH (16),
    .BITS_ADC       (8),
    .RAM_ADDR_WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rqst_data   (rqst_data),
    .stop        (stop),
    .num_samples (num_samples),
    .wr_ptr      (wr_ptr),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .tx          (bus.master),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM read port: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"},   rd_en,       0);
    check({tag, "_rd_addr"}, rd_addr,     0);
    check({tag, "_tx_data"}, bus.tx_data, 0);
    check({tag, "_tx_rdy"},  bus.tx_rdy,  0);
    check({tag, "_tx_eof"},  bus.tx_eof,  0);
    check({tag, "_busy"},    busy,        0);
  endtask

  // One request and the expected frame: address (wr - n + k) mod 256, data mem[addr],
  // eof on the last byte, fixed 3-cycle byte cadence, optional stop/reset/second request.
  task automatic frame(input int wr, input int ns, input int d,
                       input int stop_k, input int rq2_k, input int rst_k);
    int n;
    int a;
    n = (ns > 256) ? 256 : ns;
    wr_ptr      = 8'(wr);
    num_samples = 16'(ns);
    rqst_data   = 1'b1;
    tick();
    rqst_data   = 1'b0;
    wr_ptr      = 8'($urandom);
    num_samples = 16'($urandom_range(1, 400));
    if (n == 0) begin
      repeat (3) begin
        check("zero_busy",  busy,       0);
        check("zero_rd_en", rd_en,      0);
        check("zero_rdy",   bus.tx_rdy, 0);
        tick();
      end
      return;
    end
    for (int k = 0; k < n; k++) begin
      a = (wr - n + k) & 255;
      check("fetch_rd_en", rd_en,      1);
      check("fetch_addr",  rd_addr,    a);
      check("fetch_busy",  busy,       1);
      check("fetch_rdy",   bus.tx_rdy, 0);
      if (k == rq2_k) rqst_data = 1'b1;
      tick();
      rqst_data = 1'b0;
      check("cap_rd_en", rd_en,      0);
      check("cap_addr",  rd_addr,    a);
      check("cap_rdy",   bus.tx_rdy, 0);
      tick();
      check("pres_rdy",   bus.tx_rdy,  1);
      check("pres_data",  bus.tx_data, mem[a]);
      check("pres_eof",   bus.tx_eof,  (k == n - 1) ? 1 : 0);
      check("pres_rd_en", rd_en,       0);
      if (k == rst_k) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midrst");
        return;
      end
      repeat (d) begin
        tick();
        check("hold_rdy",   bus.tx_rdy,  1);
        check("hold_data",  bus.tx_data, mem[a]);
        check("hold_eof",   bus.tx_eof,  (k == n - 1) ? 1 : 0);
        check("hold_rd_en", rd_en,       0);
        check("hold_addr",  rd_addr,     a);
      end
      if (k == stop_k) begin
        stop       = 1'b1;
        bus.tx_ack = 1'b1;
        tick();
        stop       = 1'b0;
        bus.tx_ack = 1'b0;
        check("stop_rdy",   bus.tx_rdy, 0);
        check("stop_eof",   bus.tx_eof, 0);
        check("stop_busy",  busy,       0);
        check("stop_rd_en", rd_en,      0);
        return;
      end
      bus.tx_ack = 1'b1;
      tick();
      bus.tx_ack = 1'b0;
    end
    check("end_busy",  busy,       0);
    check("end_rdy",   bus.tx_rdy, 0);
    check("end_eof",   bus.tx_eof, 0);
    check("end_rd_en", rd_en,      0);
  endtask

  initial begin
    rst         = 1'b1;
    rqst_data   = 1'b0;
    stop        = 1'b0;
    num_samples = '0;
    wr_ptr      = '0;
    bus.tx_ack  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Basic frame and wrap-around with identity RAM contents.
    frame(10, 4, 0, -1, -1, -1);
    frame(2, 5, 0, -1, -1, -1);

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // Backpressure: ack withheld five cycles per byte.
    frame(int'($urandom_range(0, 255)), 3, 5, -1, -1, -1);

    // Zero count and clamp to full depth.
    frame(int'($urandom_range(0, 255)), 0, 0, -1, -1, -1);
    frame(0, 300, 0, -1, -1, -1);

    // Stop together with ack on byte 4, then a fresh request.
    frame(int'($urandom_range(0, 255)), 10, 0, 3, -1, -1);
    frame(int'($urandom_range(0, 255)), 6, 1, -1, -1, -1);

    // stop with rqst_data in IDLE is ignored.
    wr_ptr      = 8'd50;
    num_samples = 16'd3;
    rqst_data   = 1'b1;
    stop        = 1'b1;
    tick();
    rqst_data   = 1'b0;
    stop        = 1'b0;
    check("stop_rqst_busy",  busy,  0);
    check("stop_rqst_rd_en", rd_en, 0);
    tick();

    // Second request during byte 2 is ignored; reset while presenting drops the frame.
    frame(int'($urandom_range(0, 255)), 5, 0, -1, 1, -1);
    frame(int'($urandom_range(0, 255)), 7, 2, -1, -1, 2);
    frame(int'($urandom_range(0, 255)), 3, 0, -1, -1, -1);

    // Random frames with random backpressure.
    for (int t = 0; t < 8; t++) begin
      frame(int'($urandom_range(0, 255)), int'($urandom_range(1, 20)),
            int'($urandom_range(0, 3)), -1, -1, -1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
